// File: rtl/accumulator_controller.sv
// accumulator_controller: sequences write/accumulate and read commands onto the
// accumulator register file with wrap-around rows and pipeline-latency guards.
module accumulator_controller #(
    parameter int REGISTER_DEPTH = 512,
    parameter int LENGTH_WIDTH = 16,
    parameter int WRITE_LATENCY = 7,
    parameter int READ_LATENCY = 2,
    localparam int ADDR_WIDTH = $clog2(REGISTER_DEPTH),
    localparam int DW = $clog2(WRITE_LATENCY + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_read,
    input  logic                    cmd_accumulate,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LENGTH_WIDTH-1:0] cmd_length,
    input  logic                    wr_row_valid,
    output logic                    rf_enable,
    output logic [ADDR_WIDTH-1:0]   rf_write_addr,
    output logic                    rf_write_enable,
    output logic                    rf_accumulate,
    output logic [ADDR_WIDTH-1:0]   rf_read_addr,
    output logic                    rd_row_valid,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [2:0] {IDLE, WRITE, DRAIN, READ, FLUSH} state_t;
    state_t state;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [LENGTH_WIDTH-1:0] remaining;
    logic [DW-1:0] drain;
    logic acc;
    logic [READ_LATENCY-1:0] pipe, pipe_next;
    logic issue;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return a == ADDR_WIDTH'(REGISTER_DEPTH - 1) ? '0 : a + 1'b1;
    endfunction

    assign cmd_ready = enable && !rst && state == IDLE;
    assign issue = enable && state == READ;
    assign pipe_next = READ_LATENCY'({pipe, issue});
    assign rf_enable = enable;
    assign rf_write_enable = enable && wr_row_valid && state == WRITE;
    assign rf_accumulate = acc && state == WRITE;
    assign rf_write_addr = wr_addr;
    assign rf_read_addr = rd_addr;
    assign rd_row_valid = pipe[READ_LATENCY-1] && enable;
    assign busy = state != IDLE;

    // Zero-length commands pass through a one-cycle DRAIN so done lands one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wr_addr <= '0;
            rd_addr <= '0;
            remaining <= '0;
            drain <= '0;
            acc <= 1'b0;
            pipe <= '0;
            done <= 1'b0;
        end else if (enable) begin
            done <= 1'b0;
            pipe <= pipe_next;
            case (state)
                IDLE: if (cmd_valid) begin
                    acc <= cmd_accumulate;
                    remaining <= cmd_length;
                    if (cmd_read) rd_addr <= cmd_addr;
                    else wr_addr <= cmd_addr;
                    if (cmd_length == '0) begin
                        state <= DRAIN;
                        drain <= DW'(1);
                    end else state <= cmd_read ? READ : WRITE;
                end
                WRITE: if (wr_row_valid) begin
                    wr_addr <= next_addr(wr_addr);
                    remaining <= remaining - 1'b1;
                    if (remaining == LENGTH_WIDTH'(1)) begin
                        state <= DRAIN;
                        drain <= DW'(WRITE_LATENCY);
                    end
                end
                DRAIN: begin
                    drain <= drain - 1'b1;
                    if (drain == DW'(1)) begin
                        state <= IDLE;
                        done <= 1'b1;
                    end
                end
                READ: begin
                    rd_addr <= next_addr(rd_addr);
                    remaining <= remaining - 1'b1;
                    if (remaining == LENGTH_WIDTH'(1)) state <= FLUSH;
                end
                FLUSH: if (pipe_next == '0) begin
                    state <= IDLE;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
